// File: rtl/gsim_b_gen.sv
// Forward banded-matrix product b = A*x for the Gauss-Seidel round-trip path.
// Collects 16 Q16.16 x words, then streams 16 rounded, saturated int16 b words.
module gsim_b_gen #(
  parameter int N  = 16,
  parameter int XW = 32,
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst_in,
  input  logic          x_en,
  input  logic [XW-1:0] x_in,
  output logic          busy,
  output logic          b_en,
  output logic [BW-1:0] b_out,
  output logic          sat,
  output logic          done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CALC, S_SEND, S_DONE
  } state_t;

  state_t state, nxt;

  logic signed [XW-1:0] x_q [N];
  logic [4:0]           cnt;
  logic                 accept;
  logic                 row_ld;
  logic                 busy_d;
  logic                 done_d;
  logic signed [37:0]   t [7];
  logic signed [37:0]   s1, s2, s3;
  logic signed [37:0]   acc, acc_q;
  logic                 acc_v;
  logic signed [37:0]   sh;
  logic                 ovf;
  logic [BW-1:0]        b_sat;

  assign accept = x_en && (state == S_IDLE || state == S_LOAD);

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (x_en) nxt = S_LOAD;
      S_LOAD: if (x_en && cnt == 5'd15) nxt = S_CALC;
      S_CALC: nxt = S_SEND;
      S_SEND: if (cnt == 5'd16 && !acc_v) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    row_ld = (state == S_CALC) ||
             (state == S_SEND && cnt < 5'd16);
    busy_d = (nxt != S_IDLE);
    done_d = (nxt == S_DONE);
  end

  // Seven taps around row cnt; indices outside the vector read as zero.
  always_comb begin
    int j;
    j = 0;
    for (int d = 0; d < 7; d++) begin
      j = int'(cnt) + d - 3;
      t[d] = (j >= 0 && j < N) ? 38'(x_q[j[3:0]]) : '0;
    end
    s1  = t[2] + t[4];
    s2  = t[1] + t[5];
    s3  = t[0] + t[6];
    acc = (t[3] <<< 4) + (t[3] <<< 2)
        - ((s1 <<< 3) + (s1 <<< 2) + s1)
        + (s2 <<< 2) + (s2 <<< 1)
        - s3;
  end

  always_comb begin
    sh    = (acc_q + 38'sd32768) >>> 16;
    ovf   = (sh > 38'sd32767) || (sh < -38'sd32768);
    b_sat = ovf ? (sh[37] ? 16'h8000 : 16'h7FFF) : sh[15:0];
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < N; i++) x_q[i] <= '0;
      cnt   <= '0;
      acc_q <= '0;
      acc_v <= 1'b0;
      busy  <= 1'b0;
      b_en  <= 1'b0;
      b_out <= '0;
      sat   <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < N - 1; i++) x_q[i] <= x_q[i+1];
        x_q[N-1] <= $signed(x_in);
      end
      unique case (state)
        S_IDLE: if (x_en) cnt <= 5'd1;
        S_LOAD: if (x_en) cnt <= (cnt == 5'd15) ? 5'd0 : cnt + 5'd1;
        S_CALC: cnt <= 5'd1;
        S_SEND: if (cnt < 5'd16) cnt <= cnt + 5'd1;
        S_DONE: cnt <= 5'd0;
        default: cnt <= 5'd0;
      endcase
      acc_v <= row_ld;
      if (row_ld) acc_q <= acc;
      b_en <= acc_v;
      if (acc_v) b_out <= b_sat;
      if (accept && state == S_IDLE) sat <= 1'b0;
      else if (acc_v && ovf)         sat <= 1'b1;
      busy <= busy_d;
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_gsim_b_gen.sv
// Directed bench for gsim_b_gen: reference model of b = A*x plus
// a per-cycle compare of the b stream, done pulse and sticky sat.
module tb_gsim_b_gen;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        x_en;
  logic [31:0] x_in;
  logic        busy;
  logic        b_en;
  logic [15:0] b_out;
  logic        sat;
  logic        done;

  gsim_b_gen dut (
    .clk   (clk),
    .rst_in(rst_in),
    .x_en  (x_en),
    .x_in  (x_in),
    .busy  (busy),
    .b_en  (b_en),
    .b_out (b_out),
    .sat   (sat),
    .done  (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string n, input longint a, input longint e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, a, e, cyc);
    end
  endtask

  // b_i from the row rule, half-up rounding, int16 clamp.
  task automatic model(input int xv[16], output int b[16], output bit s);
    int coef[7];
    longint acc;
    longint r;
    coef = '{-1, 6, -13, 20, -13, 6, -1};
    s = 1'b0;
    for (int i = 0; i < 16; i++) begin
      acc = 0;
      for (int d = 0; d < 7; d++) begin
        if (i + d - 3 >= 0 && i + d - 3 < 16)
          acc += longint'(coef[d]) * longint'(xv[i+d-3]);
      end
      r = (acc + 64'sd32768) >>> 16;
      if (r > 32767) begin r = 32767; s = 1'b1; end
      if (r < -32768) begin r = -32768; s = 1'b1; end
      b[i] = int'(r);
    end
  endtask

  int E = -1000;
  int exp_b[16];
  bit exp_sat;

  always @(negedge clk) begin
    int k;
    k = cyc - E;
    chk("b_en", longint'(b_en), longint'(k >= 2 && k <= 17));
    chk("done", longint'(done), longint'(k == 18));
    if (k >= 2 && k <= 17)
      chk($sformatf("b%0d", k - 1), longint'($signed(b_out)),
          longint'(exp_b[k-2]));
    if (k == 18)
      chk("sat_at_done", longint'(sat), longint'(exp_sat));
  end

  task automatic pin(input string n, input int xv[16],
                     input int lit[16], input bit ls);
    int mb[16];
    bit ms;
    model(xv, mb, ms);
    for (int i = 0; i < 16; i++)
      chk($sformatf("%s_b%0d", n, i + 1), longint'(mb[i]), longint'(lit[i]));
    chk({n, "_sat"}, longint'(ms), longint'(ls));
  endtask

  task automatic load_vec(input int xv[16], input bit gap, input bit cf);
    for (int i = 0; i < 16; i++) begin
      if (gap && (i % 4) == 2) begin
        x_en = 1'b0;
        repeat (3) @(negedge clk);
      end
      x_en = 1'b1;
      x_in = xv[i];
      if (i == 15) begin
        E = cyc + 1;
        model(xv, exp_b, exp_sat);
      end
      @(negedge clk);
      if (i == 0 && cf) begin
        chk("busy_first", longint'(busy), 1);
        chk("sat_clear", longint'(sat), 0);
      end
    end
    x_en = 1'b0;
  endtask

  task automatic finish_vec(input bit junk);
    while (cyc < E + 18) @(negedge clk);
    chk("busy_in_done", longint'(busy), 1);
    if (junk) begin
      x_en = 1'b1;
      x_in = 32'h1234_5678;
    end
    @(negedge clk);
    x_en = 1'b0;
    chk("busy_idle", longint'(busy), 0);
    chk("sat_held", longint'(sat), longint'(exp_sat));
  endtask

  int zv[16], imp[16], ones[16], half[16], big[16];
  int l_imp[16], l_ones[16], l_half[16], l_big[16];

  initial begin
    for (int i = 0; i < 16; i++) begin
      zv[i] = 0; imp[i] = 0; ones[i] = 65536; half[i] = 0; big[i] = 0;
      l_imp[i] = 0; l_half[i] = 0; l_big[i] = 0; l_ones[i] = 4;
    end
    imp[7] = 65536;
    half[0] = 32768;
    big[7] = 32'h7FFF_FFFF;
    l_imp[4] = -1; l_imp[5] = 6; l_imp[6] = -13; l_imp[7] = 20;
    l_imp[8] = -13; l_imp[9] = 6; l_imp[10] = -1;
    l_ones[0] = 12; l_ones[1] = -1; l_ones[2] = 5;
    l_ones[13] = 5; l_ones[14] = -1; l_ones[15] = 12;
    l_half[0] = 10; l_half[1] = -6; l_half[2] = 3; l_half[3] = 0;
    l_big[4] = -32768; l_big[5] = 32767; l_big[6] = -32768;
    l_big[7] = 32767; l_big[8] = -32768; l_big[9] = 32767;
    l_big[10] = -32768;

    rst_in = 1'b1;
    x_en   = 1'b0;
    x_in   = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_b_en", longint'(b_en), 0);
    chk("rst_b_out", longint'(b_out), 0);
    chk("rst_sat", longint'(sat), 0);
    chk("rst_done", longint'(done), 0);
    rst_in = 1'b0;
    @(negedge clk);

    pin("imp", imp, l_imp, 1'b0);
    pin("ones", ones, l_ones, 1'b0);
    pin("half", half, l_half, 1'b0);
    pin("big", big, l_big, 1'b1);

    load_vec(zv, 1'b0, 1'b1);   finish_vec(1'b0);
    load_vec(imp, 1'b0, 1'b0);  finish_vec(1'b1);
    load_vec(ones, 1'b0, 1'b1); finish_vec(1'b0);
    load_vec(half, 1'b0, 1'b0); finish_vec(1'b0);
    load_vec(big, 1'b0, 1'b0);  finish_vec(1'b0);
    repeat (3) @(negedge clk);
    chk("sat_sticky_idle", longint'(sat), 1);
    load_vec(imp, 1'b1, 1'b1);  finish_vec(1'b0);

    load_vec(ones, 1'b0, 1'b0);
    while (cyc < E + 5) @(negedge clk);
    x_en = 1'b1;
    x_in = 32'h7FFF_0000;
    repeat (2) @(negedge clk);
    x_en = 1'b0;
    finish_vec(1'b0);

    load_vec(big, 1'b0, 1'b0);
    while (cyc < E + 6) @(negedge clk);
    #2;
    rst_in = 1'b1;
    E = -1000;
    #1;
    chk("arst_b_en", longint'(b_en), 0);
    chk("arst_busy", longint'(busy), 0);
    chk("arst_sat", longint'(sat), 0);
    chk("arst_b_out", longint'(b_out), 0);
    repeat (2) @(negedge clk);
    rst_in = 1'b0;
    repeat (25) @(negedge clk);

    load_vec(half, 1'b0, 1'b1); finish_vec(1'b0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
